// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundle of every signal between the decode side, the forwarding sources and
// the ID/EX pipeline register. clk and rst are not part of the bundle.
//
// Handshake: there is no valid/ready pair on this stage. id_valid marks a real
// instruction in decode; ex_stall is a level hold request from downstream;
// stall_id is the stage's combinational request to freeze PC and IF/ID.
// An instruction is accepted on a rising edge only when flush, ex_stall and
// the load-use condition are all low.
//
// Modports:
//   master - decode/hazard side: drives id_*, mem_fwd, wb_fwd, flush, ex_stall
//            and observes stall_id and ex_*.
//   slave  - the pipeline register itself (id_ex_stage).
// ---------------------------------------------------------------------------
interface id_ex_stage_if;
   logic        id_valid;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic [31:0] id_imm;
   logic [14:0] id_regs;        // {rs, rt, dest}
   logic [4:0]  id_shamt;
   logic [4:0]  id_aluc;
   logic [4:0]  id_ctrl;        // {alusrc, rt_used, regwrite, memread, memwrite}
   logic [37:0] mem_fwd;        // {regwrite, rd, result} from EX/MEM
   logic [37:0] wb_fwd;         // {regwrite, rd, result} from MEM/WB
   logic        flush;
   logic        ex_stall;
   logic        stall_id;
   logic        ex_valid;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [4:0]  ex_shamt;
   logic [4:0]  ex_aluc;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_ctrl;        // {regwrite, memread, memwrite}
   logic [31:0] ex_store_data;

   modport master (
      output id_valid, id_rs_data, id_rt_data, id_imm, id_regs, id_shamt,
             id_aluc, id_ctrl, mem_fwd, wb_fwd, flush, ex_stall,
      input  stall_id, ex_valid, ex_a, ex_b, ex_shamt, ex_aluc, ex_rd,
             ex_ctrl, ex_store_data
   );

   modport slave (
      input  id_valid, id_rs_data, id_rt_data, id_imm, id_regs, id_shamt,
             id_aluc, id_ctrl, mem_fwd, wb_fwd, flush, ex_stall,
      output stall_id, ex_valid, ex_a, ex_b, ex_shamt, ex_aluc, ex_rd,
             ex_ctrl, ex_store_data
   );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with operand forwarding and load-use detection.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears every registered field
//   bus  - id_ex_stage_if.slave: decode inputs, forwarding buses, flush,
//          ex_stall in; stall_id and the registered/forwarded ex_* out
//
// Edge priority: flush > ex_stall (hold) > load-use bubble > normal load.
// Forwarding is applied after the register, so a result that appears on
// mem_fwd/wb_fwd while the instruction sits in EX still reaches ex_a/ex_b.
// ---------------------------------------------------------------------------
module id_ex_stage (
   input logic          clk,
   input logic          rst,
   id_ex_stage_if.slave bus
);

   logic        valid_q,   valid_d;
   logic [31:0] rs_data_q, rs_data_d;
   logic [31:0] rt_data_q, rt_data_d;
   logic [31:0] imm_q,     imm_d;
   logic [4:0]  rs_q,      rs_d;
   logic [4:0]  rt_q,      rt_d;
   logic [4:0]  rd_q,      rd_d;
   logic [4:0]  shamt_q,   shamt_d;
   logic [4:0]  aluc_q,    aluc_d;
   logic        alusrc_q,  alusrc_d;
   logic [2:0]  ctrl_q,    ctrl_d;

   logic [31:0] fwd_rs;
   logic [31:0] fwd_rt;
   logic        load_use;

   // Newest producer wins: EX/MEM is younger than MEM/WB. r0 never forwards.
   function automatic logic [31:0] fwd_sel(input logic [4:0]  idx,
                                           input logic [31:0] regval,
                                           input logic [37:0] mem_src,
                                           input logic [37:0] wb_src);
      logic [31:0] r;
      r = regval;
      if (idx != 5'd0) begin
         if (mem_src[37] && (mem_src[36:32] == idx)) begin
            r = mem_src[31:0];
         end else if (wb_src[37] && (wb_src[36:32] == idx)) begin
            r = wb_src[31:0];
         end
      end
      return r;
   endfunction

   assign fwd_rs = fwd_sel(rs_q, rs_data_q, bus.mem_fwd, bus.wb_fwd);
   assign fwd_rt = fwd_sel(rt_q, rt_data_q, bus.mem_fwd, bus.wb_fwd);

   // A load in EX cannot forward its data yet; an ID consumer must wait.
   assign load_use = valid_q && ctrl_q[1] && (rd_q != 5'd0) && bus.id_valid &&
                     ((rd_q == bus.id_regs[14:10]) ||
                      (bus.id_ctrl[3] && (rd_q == bus.id_regs[9:5])));

   always_comb begin
      valid_d   = valid_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      shamt_d   = shamt_q;
      aluc_d    = aluc_q;
      alusrc_d  = alusrc_q;
      ctrl_d    = ctrl_q;
      if (bus.flush || (!bus.ex_stall && load_use)) begin
         valid_d = 1'b0;
         ctrl_d  = 3'b000;
         aluc_d  = 5'b00000;
         rd_d    = 5'd0;
      end else if (bus.ex_stall) begin
         // Capture forwarded values so they survive once the source moves on.
         rs_data_d = fwd_rs;
         rt_data_d = fwd_rt;
      end else begin
         valid_d   = bus.id_valid;
         rs_data_d = bus.id_rs_data;
         rt_data_d = bus.id_rt_data;
         imm_d     = bus.id_imm;
         rs_d      = bus.id_regs[14:10];
         rt_d      = bus.id_regs[9:5];
         rd_d      = bus.id_regs[4:0];
         shamt_d   = bus.id_shamt;
         aluc_d    = bus.id_aluc;
         alusrc_d  = bus.id_ctrl[4];
         ctrl_d    = bus.id_valid ? bus.id_ctrl[2:0] : 3'b000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         rs_data_q <= 32'd0;
         rt_data_q <= 32'd0;
         imm_q     <= 32'd0;
         rs_q      <= 5'd0;
         rt_q      <= 5'd0;
         rd_q      <= 5'd0;
         shamt_q   <= 5'd0;
         aluc_q    <= 5'd0;
         alusrc_q  <= 1'b0;
         ctrl_q    <= 3'b000;
      end else begin
         valid_q   <= valid_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         shamt_q   <= shamt_d;
         aluc_q    <= aluc_d;
         alusrc_q  <= alusrc_d;
         ctrl_q    <= ctrl_d;
      end
   end

   assign bus.stall_id      = load_use || bus.ex_stall;
   assign bus.ex_valid      = valid_q;
   assign bus.ex_a          = fwd_rs;
   assign bus.ex_store_data = fwd_rt;
   assign bus.ex_b          = alusrc_q ? imm_q : fwd_rt;
   assign bus.ex_shamt      = shamt_q;
   assign bus.ex_aluc       = aluc_q;
   assign bus.ex_rd         = rd_q;
   assign bus.ex_ctrl       = ctrl_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port id_valid, input, 1, decode stage holds a real instruction.
REQ-004 SHALL have port id_rs_data, input, 32, register-file read of rs.
REQ-005 SHALL have port id_rt_data, input, 32, register-file read of rt.
REQ-006 SHALL have port id_imm, input, 32, already-extended immediate.
REQ-007 SHALL have port id_regs, input, 15, {rs[14:10], rt[9:5], dest[4:0]}.
REQ-008 SHALL have port id_shamt, input, 5, shift amount.
REQ-009 SHALL have port id_aluc, input, 5, ALU op code, passed unchanged.
REQ-010 SHALL have port id_ctrl, input, 5, {alusrc, rt_used, regwrite, memread, memwrite}.
REQ-011 SHALL have port mem_fwd, input, 38, {regwrite, rd[4:0], result[31:0]} from the EX/MEM stage.
REQ-012 SHALL have port wb_fwd, input, 38, {regwrite, rd[4:0], result[31:0]} from the MEM/WB stage.
REQ-013 SHALL have port flush, input, 1, kill the instruction entering EX.
REQ-014 SHALL have port ex_stall, input, 1, downstream hold request.
REQ-015 SHALL have port stall_id, output, 1, freeze PC and IF/ID.
REQ-016 SHALL have port ex_valid, output, 1, EX slot holds a real instruction.
REQ-017 SHALL have port ex_a, output, 32, forwarded ALU operand a.
REQ-018 SHALL have port ex_b, output, 32, ALU operand b (immediate or forwarded rt).
REQ-019 SHALL have port ex_shamt, output, 5, registered shift amount.
REQ-020 SHALL have port ex_aluc, output, 5, registered ALU op code.
REQ-021 SHALL have port ex_rd, output, 5, registered destination register.
REQ-022 SHALL have port ex_ctrl, output, 3, {regwrite, memread, memwrite}.
REQ-023 SHALL have port ex_store_data, output, 32, forwarded rt value for stores.

Function
REQ-024 SHALL be one pipeline register, latency 1 cycle from ID inputs to ex_* outputs.
REQ-025 SHALL update state on the clk rising edge, in priority order: flush, ex_stall, load-use bubble, normal load.
REQ-026 Forwarding SHALL be combinational on the registered operands: mem_fwd wins over wb_fwd, then the registered value. A source matches only when its regwrite=1, its rd equals the register index, and the index is nonzero.
REQ-027 ex_a SHALL be the forwarded rs value. ex_store_data SHALL be the forwarded rt value. ex_b SHALL be the registered imm when alusrc=1, and ex_store_data otherwise.
REQ-028 Load-use SHALL be true when all of these hold:
- ex_valid=1, ex memread=1, ex_rd!=0, id_valid=1;
- ex_rd equals id rs, or ex_rd equals id rt with rt_used=1.
REQ-029 stall_id SHALL equal load-use OR ex_stall, and SHALL be combinational.
REQ-030 On load-use without flush or ex_stall, the stage SHALL load a bubble: ex_valid=0, ex_ctrl=0, ex_aluc=5'b00000, ex_rd=0.
REQ-031 On ex_stall without flush, all fields SHALL hold. The stored rs/rt data SHALL be overwritten with their forwarded values so that a value forwarded during the hold is retained.
REQ-032 On flush, the stage SHALL load a bubble regardless of ex_stall or load-use.
REQ-033 On normal load, all id_* fields SHALL be captured and ex_valid SHALL equal id_valid. When id_valid=0, ex_ctrl SHALL be forced to 0.

Reset
REQ-034 While rst=1, all registered fields SHALL be 0 asynchronously: ex_valid=0, ex_ctrl=0, ex_aluc=0, ex_rd=0, data fields 0.
REQ-035 After reset, stall_id SHALL be 0 unless ex_stall=1. The first rising edge after rst falls SHALL perform a normal load.

Verification
REQ-036 Issue add r3,r1,r2 with r1=5 and r2=7 from the regfile and no forwarding -> next cycle ex_a=5, ex_b=7, ex_aluc=00000, ex_valid=1.
REQ-037 Set mem_fwd={1,r1,0x10} and wb_fwd={1,r1,0x20} with EX rs=r1 -> ex_a=0x10. Drop mem_fwd -> ex_a=0x20. Use rs=r0 with both matching r0 -> ex_a equals the registered value.
REQ-038 Put lw r4 in EX and add r5,r4,r6 in ID -> stall_id=1 that cycle, the next cycle shows the bubble (ex_valid=0, ex_ctrl=000), and the add enters the following cycle.
REQ-039 Hold ex_stall=1 for 3 cycles while wb_fwd supplies r2=0x55 only in cycle 1 -> outputs hold, ex_store_data stays 0x55 after wb_fwd clears, and stall_id=1 throughout.
REQ-040 Assert flush and ex_stall in the same cycle -> next cycle ex_valid=0 and ex_ctrl=0.
REQ-041 Assert rst asynchronously mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
